post_cov_arbiter: RTL and testbench

POST_COV_ARBITER -- requirements
Module: post_cov_arbiter

---
 rtl/post_cov_arbiter.sv | 143 ++++++++++++++
 tb/tb_post_cov_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/post_cov_arbiter.sv
// post_cov_arbiter: round-robin arbiter sharing one post-covariance engine
// between two requesters, with a bounded wait for engine completion and
// a saturating timeout counter.

`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module post_cov_arbiter #(
  parameter int unsigned N       = `FXP_N,
  parameter int unsigned FRAC    = `FXP_FRAC,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  input  logic [12*N-1:0] op0,
  input  logic [12*N-1:0] op1,
  output logic            gnt0,
  output logic            gnt1,
  output logic            rsp_valid0,
  output logic            rsp_valid1,
  output logic [4*N-1:0]  rsp_P,
  output logic            rsp_err,
  output logic            eng_start,
  output logic [4*N-1:0]  eng_k,
  output logic [4*N-1:0]  eng_h,
  output logic [4*N-1:0]  eng_p,
  input  logic            eng_done,
  input  logic [4*N-1:0]  eng_P,
  output logic            busy,
  output logic [7:0]      err_cnt
);

  localparam int unsigned OPW = 12 * N;
  localparam int unsigned QW  = 4 * N;
  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  logic            owner;        // 0: requester 0, 1: requester 1
  logic            last_served;  // resets to 1 so requester 0 wins the first tie
  logic [CW-1:0]   wait_cnt;

  logic            pick1_c;
  logic [OPW-1:0]  op_sel_c;

  // Round-robin pick: a lone request wins, a tie goes to the one not served last.
  assign pick1_c  = req1 & (~req0 | ~last_served);
  assign op_sel_c = pick1_c ? op1 : op0;

  // Arbiter FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      wait_cnt    <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      rsp_valid0  <= 1'b0;
      rsp_valid1  <= 1'b0;
      rsp_P       <= '0;
      rsp_err     <= 1'b0;
      eng_start   <= 1'b0;
      eng_k       <= '0;
      eng_h       <= '0;
      eng_p       <= '0;
      busy        <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      eng_start  <= 1'b0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            state     <= S_START;
            owner     <= pick1_c;
            gnt0      <= ~pick1_c;
            gnt1      <= pick1_c;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            eng_k     <= op_sel_c[OPW-1 -: QW];
            eng_h     <= op_sel_c[2*QW-1 -: QW];
            eng_p     <= op_sel_c[QW-1:0];
          end
        end
        S_START: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (eng_done) begin
            state      <= S_RESP;
            rsp_P      <= eng_P;
            rsp_err    <= 1'b0;
            rsp_valid0 <= ~owner;
            rsp_valid1 <= owner;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state      <= S_RESP;
            rsp_P      <= '0;
            rsp_err    <= 1'b1;
            rsp_valid0 <= ~owner;
            rsp_valid1 <= owner;
            if (err_cnt != 8'hFF) begin
              err_cnt <= err_cnt + 8'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          last_served <= owner;
          busy        <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // FRAC is carried only so integrators see the format; widths above need N alone.
  if (FRAC > N) begin : g_frac_wider_than_word
  end

endmodule

// File: tb/tb_post_cov_arbiter.sv
// tb_post_cov_arbiter: directed, table-driven bench for post_cov_arbiter
// with a small behavioural engine model.

module tb_post_cov_arbiter;

  localparam int unsigned N   = 16;
  localparam int unsigned FRAC = 8;
  localparam int unsigned TO  = 16;
  localparam int unsigned QW  = 4 * N;
  localparam int unsigned OPW = 12 * N;
  localparam int NV = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [OPW-1:0] op0, op1;
  logic           gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err, eng_start, busy;
  logic [QW-1:0]  rsp_P, eng_k, eng_h, eng_p, eng_P;
  logic           eng_done = 1'b0;
  logic [7:0]     err_cnt;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int excl_viol = 0;

  // Engine model controls
  logic          eng_never = 1'b0;
  logic          eng_hold  = 1'b0;
  logic          eng_echo  = 1'b0;
  int            eng_dly   = 1;
  logic [QW-1:0] eng_val   = '0;
  int            since     = 0;
  bit            active    = 1'b0;

  post_cov_arbiter #(.N(N), .FRAC(FRAC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_P(rsp_P), .rsp_err(rsp_err), .eng_start(eng_start),
    .eng_k(eng_k), .eng_h(eng_h), .eng_p(eng_p),
    .eng_done(eng_done), .eng_P(eng_P), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Engine: pulses done eng_dly cycles after the start cycle, or holds it high on request.
  always @(negedge clk) begin
    if (rst) active = 1'b0;
    else if (eng_start) begin active = 1'b1; since = 0; end
    else if (active) since = since + 1;
    eng_done = eng_hold | (active && !eng_never && since == eng_dly);
  end
  assign eng_P = eng_echo ? eng_p : eng_val;

  // Response counter and one-hot monitor.
  always @(negedge clk) begin
    rsp_cnt = rsp_cnt + int'(rsp_valid0) + int'(rsp_valid1);
    if ((gnt0 && gnt1) || (rsp_valid0 && rsp_valid1)) excl_viol = excl_viol + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic           who;
    logic [OPW-1:0] op;
    int             dly;
    logic [QW-1:0]  engp;
    int             lat;
    logic [QW-1:0]  exp_p;
    logic           exp_err;
  } vec_t;

  vec_t vt [NV];

  function automatic logic [QW-1:0] m4(input int a, input int b, input int c, input int d);
    return {N'(a), N'(b), N'(c), N'(d)};
  endfunction

  function automatic logic [OPW-1:0] mkop(input logic [QW-1:0] k, input logic [QW-1:0] h,
                                         input logic [QW-1:0] p);
    return {k, h, p};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_gnt(output int who, output int at, output bit ok);
    ok = 1'b0; who = -1; at = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (gnt0 || gnt1) begin who = gnt1 ? 1 : 0; at = cyc; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rsp(output int who, output int at, output bit ok);
    ok = 1'b0; who = -1; at = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (rsp_valid0 || rsp_valid1) begin who = rsp_valid1 ? 1 : 0; at = cyc; ok = 1'b1; break; end
    end
  endtask

  initial begin
    int who, gc, rc, prev_rc, r0;
    bit ok;
    logic [OPW-1:0] ta, tb2, exp_op;

    // Hand-computed vectors: lat = dly + 1 while done arrives within TIMEOUT WAIT cycles.
    vt[0] = '{1'b0, mkop(m4(128,0,0,128), m4(256,0,0,256), m4(256,0,0,256)), 7,
              m4(128,0,0,128), 8, m4(128,0,0,128), 1'b0};
    vt[1] = '{1'b1, mkop(m4(1,2,3,4), m4(5,6,7,8), m4(9,10,11,12)), 1,
              m4(16'h1111,16'h2222,16'h3333,16'h4444), 2,
              m4(16'h1111,16'h2222,16'h3333,16'h4444), 1'b0};
    vt[2] = '{1'b0, mkop(m4(16'hFFFF,0,0,16'h8000), m4(3,3,3,3), m4(7,0,0,7)), 3,
              m4(16'hABCD,1,2,16'hDCBA), 4, m4(16'hABCD,1,2,16'hDCBA), 1'b0};
    vt[3] = '{1'b1, mkop(m4(20,21,22,23), m4(24,25,26,27), m4(28,29,30,31)), 15,
              m4(16'h0F0F,0,0,16'hF0F0), 16, m4(16'h0F0F,0,0,16'hF0F0), 1'b0};
    vt[4] = '{1'b0, mkop(m4(40,41,42,43), m4(44,45,46,47), m4(48,49,50,51)), 16,
              m4(16'h7777,5,6,16'h8888), 17, m4(16'h7777,5,6,16'h8888), 1'b0};

    // Reset state
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = '0; op1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_pulses", 256'({gnt0, gnt1, rsp_valid0, rsp_valid1, eng_start}), 256'(0));
    chk("rst_rsp", 256'({rsp_P, rsp_err}), 256'(0));
    chk("rst_eng_ops", 256'({eng_k, eng_h, eng_p}), 256'(0));
    chk("rst_err_cnt", 256'(err_cnt), 256'(0));

    // Tie from reset: grants alternate 0,1,0,1 back to back; engine echoes the P operand.
    ta  = mkop(m4(1,1,1,1), m4(2,2,2,2), m4(16'hA0,16'hA1,16'hA2,16'hA3));
    tb2 = mkop(m4(3,3,3,3), m4(4,4,4,4), m4(16'hB0,16'hB1,16'hB2,16'hB3));
    op0 = ta; op1 = tb2; eng_echo = 1'b1; eng_dly = 2;
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    prev_rc = 0;
    for (int i = 0; i < 4; i++) begin
      exp_op = (i % 2 == 1) ? tb2 : ta;
      wait_gnt(who, gc, ok);
      chk("tie_gnt_seen", 256'(ok), 256'(1));
      chk("tie_order", 256'(who), 256'(i % 2));
      chk("tie_eng_ops", 256'({eng_k, eng_h, eng_p}), 256'(exp_op));
      if (i > 0) chk("tie_b2b_spacing", 256'(gc - prev_rc), 256'(2));
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      wait_rsp(who, rc, ok);
      chk("tie_rsp_owner", 256'(who), 256'(i % 2));
      chk("tie_rsp_P", 256'(rsp_P), 256'(exp_op[QW-1:0]));
      prev_rc = rc;
    end
    eng_echo = 1'b0;
    step();

    // Table-driven single-requester transactions
    for (int i = 0; i < NV; i++) begin
      eng_dly = vt[i].dly; eng_val = vt[i].engp;
      if (vt[i].who) begin op1 = vt[i].op; req1 = 1'b1; end
      else begin op0 = vt[i].op; req0 = 1'b1; end
      wait_gnt(who, gc, ok);
      chk("vec_gnt_seen", 256'(ok), 256'(1));
      chk("vec_gnt_who", 256'(who), 256'(vt[i].who));
      chk("vec_start_with_gnt", 256'(eng_start), 256'(1));
      chk("vec_eng_ops", 256'({eng_k, eng_h, eng_p}), 256'(vt[i].op));
      chk("vec_busy", 256'(busy), 256'(1));
      req0 = 1'b0; req1 = 1'b0;
      wait_rsp(who, rc, ok);
      chk("vec_rsp_who", 256'(who), 256'(vt[i].who));
      chk("vec_latency", 256'(rc - gc), 256'(vt[i].lat));
      chk("vec_rsp_P", 256'(rsp_P), 256'(vt[i].exp_p));
      chk("vec_rsp_err", 256'(rsp_err), 256'(vt[i].exp_err));
      step();
      chk("vec_idle_busy", 256'(busy), 256'(0));
      chk("vec_rsp_P_hold", 256'(rsp_P), 256'(vt[i].exp_p));
    end
    chk("vec_err_cnt", 256'(err_cnt), 256'(0));

    // Timeout: engine never finishes
    eng_never = 1'b1;
    op0 = mkop(m4(9,9,9,9), m4(8,8,8,8), m4(7,7,7,7)); req0 = 1'b1;
    wait_gnt(who, gc, ok);
    req0 = 1'b0;
    wait_rsp(who, rc, ok);
    chk("to_rsp_seen", 256'(ok), 256'(1));
    chk("to_owner", 256'(who), 256'(0));
    chk("to_latency", 256'(rc - gc), 256'(TO + 1));
    chk("to_rsp_err", 256'(rsp_err), 256'(1));
    chk("to_rsp_P", 256'(rsp_P), 256'(0));
    chk("to_err_cnt", 256'(err_cnt), 256'(1));
    step(); step();
    chk("to_err_hold", 256'(rsp_err), 256'(1));
    eng_never = 1'b0; eng_dly = 2; eng_val = m4(16'h1234,0,0,16'h4321);
    req1 = 1'b1;
    wait_gnt(who, gc, ok);
    req1 = 1'b0;
    wait_rsp(who, rc, ok);
    chk("after_to_who", 256'(who), 256'(1));
    chk("after_to_rsp", 256'({rsp_P, rsp_err}), 256'({m4(16'h1234,0,0,16'h4321), 1'b0}));
    chk("after_to_err_cnt", 256'(err_cnt), 256'(1));
    step();

    // Asynchronous reset during WAIT
    eng_never = 1'b1;
    req0 = 1'b1;
    wait_gnt(who, gc, ok);
    req0 = 1'b0;
    step(); step();
    chk("mid_busy_before", 256'(busy), 256'(1));
    r0 = rsp_cnt;
    #2 rst = 1'b1;
    #1;
    chk("mid_busy_async", 256'(busy), 256'(0));
    chk("mid_start_async", 256'(eng_start), 256'(0));
    chk("mid_err_cnt", 256'(err_cnt), 256'(0));
    @(negedge clk);
    #1 rst = 1'b0;
    eng_never = 1'b0;
    repeat (TO + 4) step();
    chk("mid_no_rsp", 256'(rsp_cnt - r0), 256'(0));
    eng_dly = 4; eng_val = m4(16'h5555,1,1,16'h6666);
    op1 = mkop(m4(11,12,13,14), m4(15,16,17,18), m4(19,20,21,22)); req1 = 1'b1;
    wait_gnt(who, gc, ok);
    req1 = 1'b0;
    chk("mid_req1_gnt", 256'(who), 256'(1));
    wait_rsp(who, rc, ok);
    chk("mid_req1_rsp", 256'({who[0], rsp_P, rsp_err}), 256'({1'b1, m4(16'h5555,1,1,16'h6666), 1'b0}));
    chk("mid_req1_lat", 256'(rc - gc), 256'(5));
    step();

    // eng_done held high in IDLE is ignored; counted from the first WAIT cycle
    eng_hold = 1'b1; eng_val = m4(16'hC0DE,2,3,16'hBEEF);
    r0 = rsp_cnt;
    repeat (4) step();
    chk("hold_idle_busy", 256'(busy), 256'(0));
    chk("hold_idle_no_rsp", 256'(rsp_cnt - r0), 256'(0));
    ta = mkop(m4(60,61,62,63), m4(64,65,66,67), m4(68,69,70,71));
    op1 = ta; req1 = 1'b1;
    wait_gnt(who, gc, ok);
    chk("hold_gnt_who", 256'(who), 256'(1));
    req1 = 1'b0; op1 = mkop(m4(1,1,1,1), m4(1,1,1,1), m4(1,1,1,1));
    step();
    chk("hold_gnt_single", 256'(gnt1), 256'(0));
    chk("hold_ops_stable", 256'({eng_k, eng_h, eng_p}), 256'(ta));
    wait_rsp(who, rc, ok);
    chk("hold_latency", 256'(rc - gc), 256'(2));
    chk("hold_rsp_P", 256'(rsp_P), 256'(m4(16'hC0DE,2,3,16'hBEEF)));
    chk("hold_ops_at_rsp", 256'({eng_k, eng_h, eng_p}), 256'(ta));
    eng_hold = 1'b0;
    step();

    chk("onehot_pulses", 256'(excl_viol), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
